seg7_scan: RTL and testbench

Parametrised, time-multiplexed seven-segment scan driver. It replaces the fixed eight-digit display path that shows the pet status and the hunger/energy/health levels. Adds over the previous generation:
- configurable digit count
- double-buffered, tear-free updates with a load handshake
- per-digit blanking and blinking (used for critical levels)
- 16-step PWM brightness

Sits between the top-level level/status formatter and the board `sseg`/`an` pins.

---
 rtl/seg7_pkg.sv | 55 +++++
 rtl/seg7_scan_hex2sseg.sv | 19 +
 rtl/seg7_scan.sv | 168 ++++++++++++++++
 tb/tb_seg7_scan.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// ============================================================================
// Module   : seg7_pkg
// Purpose  : Active-low seven-segment patterns (sseg[0]=a .. sseg[6]=g) and hex decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package seg7_pkg;

    typedef logic [0:6] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;
    localparam seg_t SEG_0     = 7'b0000001;
    localparam seg_t SEG_1     = 7'b1001111;
    localparam seg_t SEG_2     = 7'b0010010;
    localparam seg_t SEG_3     = 7'b0000110;
    localparam seg_t SEG_4     = 7'b1001100;
    localparam seg_t SEG_5     = 7'b0100100;
    localparam seg_t SEG_6     = 7'b0100000;
    localparam seg_t SEG_7     = 7'b0001111;
    localparam seg_t SEG_8     = 7'b0000000;
    localparam seg_t SEG_9     = 7'b0000100;
    localparam seg_t SEG_A     = 7'b0001000;
    localparam seg_t SEG_B     = 7'b1100000;
    localparam seg_t SEG_C     = 7'b0110001;
    localparam seg_t SEG_D     = 7'b1000010;
    localparam seg_t SEG_E     = 7'b0110000;
    localparam seg_t SEG_F     = 7'b0111000;

    function automatic seg_t hex2seg(input logic [3:0] nibble);
        seg_t seg;
        case (nibble)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_hex2sseg.sv
// ============================================================================
// Module   : hex2sseg
// Purpose  : Combinational nibble to active-low segment decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hex2sseg
    import seg7_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [0:6] o_seg
);

    assign o_seg = hex2seg(i_nib);

endmodule

`default_nettype wire

// File: rtl/seg7_scan.sv
// ============================================================================
// Module   : seg7_scan
// Purpose  : Time-multiplexed seven-segment scan driver with double-buffered
//            data, per-digit blank/blink and 16-step PWM brightness.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seg7_scan
    import seg7_pkg::*;
#(
    parameter int NDIG         = 8,
    parameter int SLOT_CYC     = 6250,
    parameter int BLINK_FRAMES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4*NDIG-1:0] num,
    input  logic [NDIG-1:0]   blank_mask,
    input  logic [NDIG-1:0]   blink_mask,
    input  logic [3:0]        bright,
    input  logic              load,
    output logic              pending,
    output logic              frame_done,
    output logic [0:6]        sseg,
    output logic [NDIG-1:0]   an
);

    localparam int PH_DIV = SLOT_CYC / 16;
    localparam int PW     = (PH_DIV > 1) ? $clog2(PH_DIV) : 1;
    localparam int DW     = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int FW     = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    // scnt is held as (phase, sub-phase) so the PWM phase needs no divider
    logic [PW-1:0]     r_pcnt;
    logic [3:0]        r_phase;
    logic [DW-1:0]     r_dig;
    logic [FW-1:0]     r_fcnt;
    logic              r_blink_on;

    logic [4*NDIG-1:0] r_sh_num;
    logic [NDIG-1:0]   r_sh_blank;
    logic [NDIG-1:0]   r_sh_blink;
    logic [3:0]        r_sh_bright;
    logic [4*NDIG-1:0] r_act_num;
    logic [NDIG-1:0]   r_act_blank;
    logic [NDIG-1:0]   r_act_blink;
    logic [3:0]        r_act_bright;

    logic              r_pending;
    logic              r_frame_done;
    logic [0:6]        r_sseg;
    logic [NDIG-1:0]   r_an;

    logic              w_pend;
    logic              w_slot_end;
    logic              w_frame_end;
    logic [3:0]        w_nib;
    logic              w_blank;
    logic              w_blink;
    logic              w_lit;
    logic [0:6]        w_seg;
    logic [NDIG-1:0]   w_an_n;

    assign w_pend      = (r_pcnt == PW'(PH_DIV - 1));
    assign w_slot_end  = w_pend && (r_phase == 4'd15);
    assign w_frame_end = w_slot_end && (r_dig == DW'(NDIG - 1));

    always_comb begin
        w_nib   = 4'h0;
        w_blank = 1'b0;
        w_blink = 1'b0;
        for (int d = 0; d < NDIG; d++) begin
            if (r_dig == DW'(d)) begin
                w_nib   = r_act_num[4*d +: 4];
                w_blank = r_act_blank[d];
                w_blink = r_act_blink[d];
            end
        end
    end

    assign w_lit = !w_blank && (!w_blink || r_blink_on) && (r_phase <= r_act_bright);

    always_comb begin
        w_an_n = '1;
        for (int d = 0; d < NDIG; d++) begin
            if (w_lit && (r_dig == DW'(d))) begin
                w_an_n[d] = 1'b0;
            end
        end
    end

    hex2sseg u_dec (
        .i_nib (w_nib),
        .o_seg (w_seg)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pcnt       <= '0;
            r_phase      <= 4'd0;
            r_dig        <= '0;
            r_fcnt       <= '0;
            r_blink_on   <= 1'b1;
            r_sh_num     <= '0;
            r_sh_blank   <= '0;
            r_sh_blink   <= '0;
            r_sh_bright  <= 4'd0;
            r_act_num    <= '0;
            r_act_blank  <= '0;
            r_act_blink  <= '0;
            r_act_bright <= 4'd0;
            r_pending    <= 1'b0;
            r_frame_done <= 1'b0;
            r_sseg       <= SEG_BLANK;
            r_an         <= '1;
        end else begin
            if (w_pend) begin
                r_pcnt  <= '0;
                r_phase <= r_phase + 4'd1;
            end else begin
                r_pcnt  <= r_pcnt + PW'(1);
            end

            if (w_slot_end) begin
                r_dig <= (r_dig == DW'(NDIG - 1)) ? '0 : r_dig + DW'(1);
            end

            if (w_frame_end) begin
                if (r_fcnt == FW'(BLINK_FRAMES - 1)) begin
                    r_fcnt     <= '0;
                    r_blink_on <= ~r_blink_on;
                end else begin
                    r_fcnt     <= r_fcnt + FW'(1);
                end
                // Transfer takes the pre-load shadow even if load coincides
                if (r_pending) begin
                    r_act_num    <= r_sh_num;
                    r_act_blank  <= r_sh_blank;
                    r_act_blink  <= r_sh_blink;
                    r_act_bright <= r_sh_bright;
                end
            end

            if (load) begin
                r_sh_num    <= num;
                r_sh_blank  <= blank_mask;
                r_sh_blink  <= blink_mask;
                r_sh_bright <= bright;
                r_pending   <= 1'b1;
            end else if (w_frame_end) begin
                r_pending   <= 1'b0;
            end

            r_frame_done <= w_frame_end;
            r_an         <= w_an_n;
            r_sseg       <= w_lit ? w_seg : SEG_BLANK;
        end
    end

    assign pending    = r_pending;
    assign frame_done = r_frame_done;
    assign sseg       = r_sseg;
    assign an         = r_an;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan.sv
// ============================================================================
// Module   : tb_seg7_scan
// Purpose  : Scoreboard bench for seg7_scan (NDIG=4, SLOT_CYC=32, BLINK_FRAMES=2).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seg7_scan;

    localparam int NDIG = 4;
    localparam int SLOT = 32;
    localparam int BLNK = 2;

    logic        clk;
    logic        rst;
    logic [15:0] num;
    logic [3:0]  blank_mask;
    logic [3:0]  blink_mask;
    logic [3:0]  bright;
    logic        load;
    logic        pending;
    logic        frame_done;
    logic [0:6]  sseg;
    logic [3:0]  an;

    seg7_scan #(.NDIG(NDIG), .SLOT_CYC(SLOT), .BLINK_FRAMES(BLNK)) dut (
        .clk        (clk),
        .rst        (rst),
        .num        (num),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .bright     (bright),
        .load       (load),
        .pending    (pending),
        .frame_done (frame_done),
        .sseg       (sseg),
        .an         (an)
    );

    typedef struct {
        logic [3:0] an;
        logic [0:6] seg;
        int         on;
        bit         blinks;
    } exp_t;

    exp_t       q[$];
    logic [0:6] seg_tab [16];
    int         total = 0;
    int         bad   = 0;
    int         fd_count;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Frames completed since reset; equals the index of the frame being shown
    always @(posedge clk or negedge rst) begin
        if (!rst)            fd_count <= 0;
        else if (frame_done) fd_count <= fd_count + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [15:0] n, input logic [3:0] b,
                           input logic [3:0] bl, input logic [3:0] bk);
        num        = n;
        bright     = b;
        blank_mask = bl;
        blink_mask = bk;
        load       = 1'b1;
        @(negedge clk);
        load       = 1'b0;
    endtask

    task automatic push_frame(input logic [15:0] n, input logic [3:0] b,
                              input logic [3:0] bl, input logic [3:0] bk);
        logic [3:0] one;
        one = 4'b0001;
        for (int d = 0; d < NDIG; d++) begin
            exp_t e;
            e.an     = ~(one << d);
            e.seg    = seg_tab[n[4*d +: 4]];
            e.on     = bl[d] ? 0 : (int'(b) + 1) * (SLOT / 16);
            e.blinks = bk[d];
            q.push_back(e);
        end
    endtask

    task automatic wait_fd(input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) found = 1'b1;
        end
        chk({tag, "_fd_timeout"}, 32'(found), 32'd1);
    endtask

    // Called at a frame_done sample; checks the following frame slot by slot
    task automatic check_frame(input string tag);
        bit bon;
        bon = 1'b1;
        for (int d = 0; d < NDIG; d++) begin
            exp_t e;
            int   eff_on;
            int   lit;
            int   badc;
            bit   hit;
            chk($sformatf("%s_sb_d%0d", tag, d), 32'(q.size() > 0), 32'd1);
            if (q.size() == 0) return;
            e      = q.pop_front();
            lit    = 0;
            badc   = 0;
            eff_on = e.on;
            for (int c = 0; c < SLOT; c++) begin
                @(negedge clk);
                if (d == 0 && c == 0) bon = ((fd_count / BLNK) % 2) == 0;
                eff_on = (e.blinks && !bon) ? 0 : e.on;
                hit = (an === e.an) && (sseg === e.seg);
                if (hit) lit++;
                if (c < eff_on) begin
                    if (!hit) badc++;
                end else if (!((an === 4'hF) && (sseg === 7'h7F))) begin
                    badc++;
                end
            end
            chk($sformatf("%s_d%0d_lit", tag, d), 32'(lit), 32'(eff_on));
            chk($sformatf("%s_d%0d_pattern", tag, d), 32'(badc), 32'd0);
        end
        chk({tag, "_frame_done_end"}, 32'(frame_done), 32'd1);
    endtask

    initial begin
        seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
        rst        = 1'b0;
        num        = '0;
        blank_mask = '0;
        blink_mask = '0;
        bright     = '0;
        load       = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_sseg", 32'(sseg), 32'h7F);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Basic load, full brightness
        push_frame(16'h1234, 4'd15, 4'b0000, 4'b0000);
        do_load(16'h1234, 4'd15, 4'b0000, 4'b0000);
        chk("load_pending", 32'(pending), 32'd1);
        wait_fd("f1234");
        chk("f1234_pending_clr", 32'(pending), 32'd0);
        check_frame("f1234");

        // PWM at bright=3: 8 lit cycles per slot
        push_frame(16'h1234, 4'd3, 4'b0000, 4'b0000);
        do_load(16'h1234, 4'd3, 4'b0000, 4'b0000);
        wait_fd("pwm");
        check_frame("pwm");

        // Blink digit 0, blank digit 1, over four frames
        for (int f = 0; f < 4; f++) push_frame(16'h5678, 4'd15, 4'b0010, 4'b0001);
        do_load(16'h5678, 4'd15, 4'b0010, 4'b0001);
        wait_fd("blink");
        check_frame("blink0");
        check_frame("blink1");
        check_frame("blink2");
        check_frame("blink3");

        // Two loads in one frame, then a load on the boundary cycle
        push_frame(16'h00E0, 4'd15, 4'b0000, 4'b0000);
        push_frame(16'hFFFF, 4'd15, 4'b0000, 4'b0000);
        do_load(16'hAAAA, 4'd15, 4'b0000, 4'b0000);
        do_load(16'h00E0, 4'd15, 4'b0000, 4'b0000);
        repeat (125) @(negedge clk);
        do_load(16'hFFFF, 4'd15, 4'b0000, 4'b0000);
        chk("bnd_frame_done", 32'(frame_done), 32'd1);
        chk("bnd_pending", 32'(pending), 32'd1);
        check_frame("f00E0");
        chk("fFFFF_pending_clr", 32'(pending), 32'd0);
        check_frame("fFFFF");

        // Asynchronous reset at dig=2, scnt=17
        repeat (81) @(negedge clk);
        chk("pre_rst_an", 32'(an), 32'hB);
        rst = 1'b0;
        #1;
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_sseg", 32'(sseg), 32'h7F);
        chk("mid_rst_pending", 32'(pending), 32'd0);
        repeat (3) @(negedge clk);
        push_frame(16'h0000, 4'd0, 4'b0000, 4'b0000);
        rst = 1'b1;
        check_frame("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
